stream_demux_1to2: RTL and testbench
====================================

// Module: stream_demux_1to2
// PURPOSE
//   Routes one valid/ready input stream to one of two buffered output streams, selected per word by in_sel.
//   Inverse of the 2:1 select path: one producer (e.g. the MMIO store path) feeds two consumers (e.g. UART TX, debug sink).
//   Each output has its own DEPTH-entry first-word-fall-through FIFO, so a stalled consumer never blocks the other channel.
// PARAMETERS
//   WIDTH   32  data bits per word
//   DEPTH   8   entries per output FIFO; power of two, >= 2
// PORTS
//   clk          in   1            rising-edge clock
//   rst_n        in   1            asynchronous reset, active low
//   in_valid     in   1            producer has a word
//   in_ready     out  1            word accepted this cycle if in_valid
//   in_data      in   WIDTH        input word
//   in_sel       in   1            destination: 0 -> out0, 1 -> out1; must be stable while in_valid
//   out0_valid   out  1            out0 FIFO non-empty
//   out0_ready   in   1            consumer 0 pops head
//   out0_data    out  WIDTH        out0 head word
//   out0_count   out  $clog2(DEPTH)+1  words held in out0 FIFO
//   out1_*       (same as out0_*, for channel 1)
//   stat0_words  out  32           words pushed into ch0 since reset (STREAM_DEMUX_STATS_EN)
//   stat1_words  out  32           words pushed into ch1 since reset (STREAM_DEMUX_STATS_EN)
// BEHAVIOUR
//   - Reset (async assert, sync release): all pointers and counts = 0; outN_valid = 0; outN_data = 0;
//     outN_count = 0; stat*_words = 0; in_ready = 1 once reset is deasserted. FIFO contents are discarded.
//   - in_ready = ~fullN for N = in_sel (combinational from registered count and in_sel; no comb path from outN_ready).
//   - Push: in_valid & in_ready -> mem[wr_ptr] <= in_data, wr_ptr++ on selected channel only.
//   - Pop: outN_valid & outN_ready -> rd_ptr++ on channel N. Pops on both channels may occur in the same cycle.
//   - Latency: a word accepted in cycle T is visible at outN_valid/outN_data in cycle T+1. No same-cycle bypass.
//   - outN_data = mem[rd_ptr] when non-empty, else 0.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is 0..DEPTH.
//   - Count update per channel: push & pop -> unchanged; push only -> +1; pop only -> -1.
//   - Full (count == DEPTH): in_ready = 0 for that selection, even if a pop occurs the same cycle. Other channel unaffected.
//   - Empty (count == 0): outN_valid = 0; outN_ready is ignored and no underflow occurs.
//   - Simultaneous push and pop on a channel with count == 1: the head pops and the new word becomes head next cycle.
//   - Word order is preserved per channel. No ordering guarantee across channels.
//   - No data loss or duplication under any handshake pattern.
//   - Reset asserted mid-transfer: all state clears immediately. Words in flight are dropped.
// CONFIGURATION
//   STREAM_DEMUX_STATS_EN defined:
//     - stat0_words/stat1_words increment by 1 on each push to their channel.
//     - Counters wrap 0xFFFFFFFF -> 0.
//   STREAM_DEMUX_STATS_EN undefined:
//     - Ports remain but are tied to 32'd0.
//     - No counter registers are synthesized.
// TESTING
//   1. Reset: rst_n=0 mid-stream -> all outN_valid = 0, counts = 0; in_ready = 1 after release.
//   2. Route: push 0xA0 (sel 0) and 0xB1 (sel 1), consumers ready -> out0 = 0xA0, out1 = 0xB1, each valid 1 cycle after accept.
//   3. Fill ch0: out0_ready = 0, push 9 words with sel 0 -> 8 accepted, in_ready = 0 on the 9th, out0_count = 8.
//      Pushes with sel 1 are still accepted in that state.
//   4. Drain order: fill ch1 with 1..8, then out1_ready = 1 -> out1_data sequence is 1,2,...,8; out1_valid drops after the 8th.
//   5. Wrap/concurrency: 20 random words alternating sel, random outN_ready -> scoreboard order matches;
//      push+pop at count 1 keeps count at 1.
//   6. Stats (macro on): push 5 words to ch0 and 3 to ch1 -> stat0 = 5, stat1 = 3. Macro off -> both read 0.

Source files
------------

// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: routes one valid/ready stream to one of two FWFT-buffered outputs chosen per word by in_sel
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_sel  producer side; in_sel 0 -> out0, 1 -> out1
//   outN_valid/outN_ready/outN_data   consumer N side, head of its DEPTH-entry FIFO (data 0 when empty)
//   outN_count                        words held in FIFO N (0..DEPTH)
//   statN_words                       pushes into channel N since reset; live only with STREAM_DEMUX_STATS_EN, else 0
module stream_demux_1to2 #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_sel,
   output logic                     out0_valid,
   input  logic                     out0_ready,
   output logic [WIDTH-1:0]         out0_data,
   output logic [$clog2(DEPTH):0]   out0_count,
   output logic                     out1_valid,
   input  logic                     out1_ready,
   output logic [WIDTH-1:0]         out1_data,
   output logic [$clog2(DEPTH):0]   out1_count,
   output logic [31:0]              stat0_words,
   output logic [31:0]              stat1_words
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [1:0] rdy, push, pop, full, nonempty;
   logic [1:0][CW-1:0] cnt;
   logic [1:0][WIDTH-1:0] head;
   assign rdy = {out1_ready, out0_ready};
   // readiness depends only on registered fill level, so a pop never frees a slot in the same cycle
   assign in_ready = ~full[in_sel];
   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0] wr_ptr, rd_ptr;
      logic [CW-1:0] n;
      assign full[c] = n == FULL;
      assign nonempty[c] = n != '0;
      assign push[c] = in_valid & in_ready & (in_sel == 1'(c));
      assign pop[c] = nonempty[c] & rdy[c];
      assign cnt[c] = n;
      assign head[c] = nonempty[c] ? mem[rd_ptr] : '0;
      always_ff @(posedge clk)
         if (push[c]) mem[wr_ptr] <= in_data;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            n <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(push[c]);
            rd_ptr <= rd_ptr + AW'(pop[c]);
            n <= n + CW'(push[c]) - CW'(pop[c]);
         end
   end
   assign out0_valid = nonempty[0];
   assign out0_data = head[0];
   assign out0_count = cnt[0];
   assign out1_valid = nonempty[1];
   assign out1_data = head[1];
   assign out1_count = cnt[1];
`ifdef STREAM_DEMUX_STATS_EN
   logic [31:0] s0, s1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s0 <= '0;
         s1 <= '0;
      end else begin
         s0 <= s0 + 32'(push[0]);
         s1 <= s1 + 32'(push[1]);
      end
   assign stat0_words = s0;
   assign stat1_words = s1;
`else
   assign stat0_words = 32'd0;
   assign stat1_words = 32'd0;
`endif
endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: scoreboard bench for stream_demux_1to2 with directed routing, fill, drain, wrap and stats cases
module tb_stream_demux_1to2;
   logic clk = 0, rst_n = 0;
   logic in_valid = 0, in_ready, in_sel = 0;
   logic [31:0] in_data = 0;
   logic out0_valid, out0_ready = 1, out1_valid, out1_ready = 1;
   logic [31:0] out0_data, out1_data, stat0_words, stat1_words;
   logic [3:0] out0_count, out1_count;
   logic [31:0] q0[$], q1[$];
   int vecs = 0, errs = 0;
   bit rnd = 0;

   stream_demux_1to2 #(.WIDTH(32), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_count(out0_count),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_count(out1_count),
      .stat0_words(stat0_words), .stat1_words(stat1_words)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: consumes the expected queue whenever a consumer handshake is about to happen
   always @(negedge clk) if (rst_n) begin
      if (out0_valid && out0_ready) begin
         if (q0.size() == 0) chk("out0 spurious word", out0_data, 32'hdead_beef);
         else chk("out0 data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
         if (q1.size() == 0) chk("out1 spurious word", out1_data, 32'hdead_beef);
         else chk("out1 data", out1_data, q1.pop_front());
      end
   end

   // entered and left at posedge+1; holds the word until accepted
   task automatic send(input logic s, input logic [31:0] d);
      int n = 0;
      bit acc;
      in_valid = 1; in_sel = s; in_data = d;
      forever begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            if (s) q1.push_back(d); else q0.push_back(d);
         end
         @(posedge clk); #1;
         if (rnd) begin out0_ready = 1'($urandom); out1_ready = 1'($urandom); end
         if (acc) break;
         if (++n > 60) begin chk("send timeout", 0, 1); break; end
      end
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      out0_ready = 1; out1_ready = 1;
      while ((out0_count != 0 || out1_count != 0) && n < 100) begin @(posedge clk); #1; n++; end
      chk("drain done", 32'(n < 100), 1);
   endtask

   task automatic do_reset();
      #1 rst_n = 0;
      q0.delete(); q1.delete();
      @(negedge clk);
      chk("rst out0_valid", out0_valid, 0);
      chk("rst out1_valid", out1_valid, 0);
      chk("rst out0_count", out0_count, 0);
      chk("rst out1_count", out1_count, 0);
      chk("rst out0_data", out0_data, 0);
      chk("rst stat0", stat0_words, 0);
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      chk("rst in_ready", in_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      // reset mid-stream with words buffered
      out0_ready = 0;
      for (int i = 0; i < 3; i++) send(0, 32'h100 + i);
      chk("pre-reset out0_count", out0_count, 3);
      do_reset();
      out0_ready = 1;
      // routing and one-cycle latency
      in_valid = 1; in_sel = 0; in_data = 32'hA0;
      @(negedge clk);
      chk("route in_ready", in_ready, 1);
      chk("no bypass out0_valid", out0_valid, 0);
      q0.push_back(32'hA0);
      @(posedge clk); #1;
      in_sel = 1; in_data = 32'hB1;
      chk("route out0_valid", out0_valid, 1);
      chk("route out0_data", out0_data, 32'hA0);
      @(negedge clk);
      chk("no bypass out1_valid", out1_valid, 0);
      q1.push_back(32'hB1);
      @(posedge clk); #1;
      in_valid = 0;
      chk("route out1_valid", out1_valid, 1);
      chk("route out1_data", out1_data, 32'hB1);
      chk("route out0 popped", out0_valid, 0);
      drain();
      // fill channel 0; channel 1 stays open
      out0_ready = 0;
      for (int i = 0; i < 8; i++) send(0, 32'hC00 + i);
      chk("fill out0_count", out0_count, 8);
      in_valid = 1; in_sel = 0; in_data = 32'hC08;
      @(negedge clk);
      chk("full in_ready sel0", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 0;
      chk("full count held", out0_count, 8);
      send(1, 32'hD1);
      chk("other ch accepted", out0_count, 8);
      // pop while full: still not ready this cycle
      out0_ready = 1; in_valid = 1; in_sel = 0; in_data = 32'hC08;
      @(negedge clk);
      chk("full+pop in_ready", in_ready, 0);
      @(posedge clk); #1;
      in_valid = 0;
      chk("after pop count", out0_count, 7);
      drain();
      // ordered drain of channel 1
      out1_ready = 0;
      for (int i = 1; i <= 8; i++) send(1, i);
      chk("fill out1_count", out1_count, 8);
      out1_ready = 1;
      repeat (8) begin @(posedge clk); #1; end
      chk("drained out1_valid", out1_valid, 0);
      chk("drained out1_count", out1_count, 0);
      chk("drained out1_data", out1_data, 0);
      chk("ch1 queue empty", q1.size(), 0);
      // push and pop together at count 1
      out0_ready = 0;
      send(0, 32'hE0);
      chk("count1 before", out0_count, 1);
      out0_ready = 1;
      send(0, 32'hE1);
      chk("count1 push+pop", out0_count, 1);
      chk("count1 new head", out0_data, 32'hE1);
      drain();
      // wrap and concurrency with random consumer stalls
      rnd = 1;
      for (int i = 0; i < 20; i++) send(1'(i), $urandom);
      rnd = 0;
      drain();
      chk("wrap q0 empty", q0.size(), 0);
      chk("wrap q1 empty", q1.size(), 0);
      // statistics
      do_reset();
      for (int i = 0; i < 5; i++) send(0, 32'h50 + i);
      for (int i = 0; i < 3; i++) send(1, 32'h60 + i);
      drain();
`ifdef STREAM_DEMUX_STATS_EN
      chk("stat0", stat0_words, 5);
      chk("stat1", stat1_words, 3);
`else
      chk("stat0 tied", stat0_words, 0);
      chk("stat1 tied", stat1_words, 0);
`endif
      chk("final q0 empty", q0.size(), 0);
      chk("final q1 empty", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
